// File: rtl/glb_pe_feeder_if.sv
// Bundle for glb_pe_feeder: command channel, GLB SRAM read port and the
// shared PE-array input bus with its per-type valid/ready pairs and tags.
// master = the feeder itself, slave = controller / SRAM / PE array side.
`ifndef DATA_BITS
`define DATA_BITS 16
`endif
`ifndef XID_BITS
`define XID_BITS 4
`endif
`ifndef YID_BITS
`define YID_BITS 4
`endif

interface glb_pe_feeder_if #(
  parameter int DATA_SIZE = `DATA_BITS,
  parameter int XID_BITS  = `XID_BITS,
  parameter int YID_BITS  = `YID_BITS,
  parameter int ADDR_BITS = 16,
  parameter int LEN_BITS  = 16
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_type;
  logic [ADDR_BITS-1:0] cmd_base_addr;
  logic [LEN_BITS-1:0]  cmd_len;
  logic [XID_BITS-1:0]  cmd_tag_X;
  logic [YID_BITS-1:0]  cmd_tag_Y;
  logic                 sram_ren;
  logic [ADDR_BITS-1:0] sram_addr;
  logic [DATA_SIZE-1:0] sram_rdata;
  logic                 GLB_ifmap_valid, GLB_filter_valid, GLB_ipsum_valid;
  logic                 GLB_ifmap_ready, GLB_filter_ready, GLB_ipsum_ready;
  logic [DATA_SIZE-1:0] GLB_data_in;
  logic [XID_BITS-1:0]  ifmap_tag_X, filter_tag_X, ipsum_tag_X;
  logic [YID_BITS-1:0]  ifmap_tag_Y, filter_tag_Y, ipsum_tag_Y;
  logic                 busy;
  logic                 done;
  logic [31:0]          stall_cycles;

  modport master (
    input  cmd_valid, cmd_type, cmd_base_addr, cmd_len, cmd_tag_X, cmd_tag_Y,
    output cmd_ready,
    output sram_ren, sram_addr,
    input  sram_rdata,
    output GLB_ifmap_valid, GLB_filter_valid, GLB_ipsum_valid,
    input  GLB_ifmap_ready, GLB_filter_ready, GLB_ipsum_ready,
    output GLB_data_in,
    output ifmap_tag_X, filter_tag_X, ipsum_tag_X,
    output ifmap_tag_Y, filter_tag_Y, ipsum_tag_Y,
    output busy, done, stall_cycles
  );

  modport slave (
    output cmd_valid, cmd_type, cmd_base_addr, cmd_len, cmd_tag_X, cmd_tag_Y,
    input  cmd_ready,
    input  sram_ren, sram_addr,
    output sram_rdata,
    input  GLB_ifmap_valid, GLB_filter_valid, GLB_ipsum_valid,
    output GLB_ifmap_ready, GLB_filter_ready, GLB_ipsum_ready,
    input  GLB_data_in,
    input  ifmap_tag_X, filter_tag_X, ipsum_tag_X,
    input  ifmap_tag_Y, filter_tag_Y, ipsum_tag_Y,
    input  busy, done, stall_cycles
  );
endinterface

// File: rtl/glb_pe_feeder.sv
// GLB -> PE array transmitter. Takes one command, streams cmd_len consecutive
// SRAM words onto GLB_data_in through a 2-entry skid FIFO using the selected
// type's valid/ready pair. Optional stall counter: define FEEDER_PERF_CNT_EN.
`ifndef DATA_BITS
`define DATA_BITS 16
`endif
`ifndef XID_BITS
`define XID_BITS 4
`endif
`ifndef YID_BITS
`define YID_BITS 4
`endif

module glb_pe_feeder #(
  parameter int DATA_SIZE = `DATA_BITS,
  parameter int XID_BITS  = `XID_BITS,
  parameter int YID_BITS  = `YID_BITS,
  parameter int ADDR_BITS = 16,
  parameter int LEN_BITS  = 16
) (
  input  logic             clk,
  input  logic             rst,
  glb_pe_feeder_if.master  bus
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t               state;
  logic [1:0]           sel_type;
  logic [ADDR_BITS-1:0] ptr;
  logic [LEN_BITS-1:0]  remaining;
  logic [DATA_SIZE-1:0] fifo_mem [2];
  logic                 wr_idx, rd_idx;
  logic [1:0]           fifo_count;
  logic                 inflight;
  logic                 fifo_empty, sel_valid, sel_ready, pop, issue, accept;
  logic [2:0]           occ;

  // Handshake decode: selected ready, pop, and read credit (FIFO + in-flight <= 2)
  always_comb begin
    fifo_empty = (fifo_count == 2'd0);
    sel_valid  = !fifo_empty;
    sel_ready  = 1'b0;
    unique case (sel_type)
      2'd0:    sel_ready = bus.GLB_ifmap_ready;
      2'd1:    sel_ready = bus.GLB_filter_ready;
      2'd2:    sel_ready = bus.GLB_ipsum_ready;
      default: sel_ready = 1'b0;
    endcase
    pop    = sel_valid && sel_ready;
    occ    = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    issue  = (state == STREAM) && (occ < 3'd2);
    accept = (state == IDLE) && bus.cmd_valid && bus.cmd_ready;
  end

  assign bus.sram_ren         = issue;
  assign bus.sram_addr        = issue ? ptr : '0;
  assign bus.GLB_ifmap_valid  = sel_valid && (sel_type == 2'd0);
  assign bus.GLB_filter_valid = sel_valid && (sel_type == 2'd1);
  assign bus.GLB_ipsum_valid  = sel_valid && (sel_type == 2'd2);
  assign bus.GLB_data_in      = fifo_empty ? '0 : fifo_mem[rd_idx];

  // Control FSM, FIFO bookkeeping, tag registers and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      sel_type         <= 2'd0;
      remaining        <= '0;
      inflight         <= 1'b0;
      fifo_count       <= 2'd0;
      wr_idx           <= 1'b0;
      rd_idx           <= 1'b0;
      bus.cmd_ready    <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.ifmap_tag_X  <= '0;
      bus.ifmap_tag_Y  <= '0;
      bus.filter_tag_X <= '0;
      bus.filter_tag_Y <= '0;
      bus.ipsum_tag_X  <= '0;
      bus.ipsum_tag_Y  <= '0;
    end else begin
      bus.done   <= 1'b0;
      inflight   <= issue;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
      if (inflight) wr_idx <= ~wr_idx;
      if (pop)      rd_idx <= ~rd_idx;
      unique case (state)
        IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (accept) begin
            sel_type      <= bus.cmd_type;
            remaining     <= bus.cmd_len;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            unique case (bus.cmd_type)
              2'd0: begin
                bus.ifmap_tag_X <= bus.cmd_tag_X;
                bus.ifmap_tag_Y <= bus.cmd_tag_Y;
              end
              2'd1: begin
                bus.filter_tag_X <= bus.cmd_tag_X;
                bus.filter_tag_Y <= bus.cmd_tag_Y;
              end
              2'd2: begin
                bus.ipsum_tag_X <= bus.cmd_tag_X;
                bus.ipsum_tag_Y <= bus.cmd_tag_Y;
              end
              default: ;
            endcase
            if ((bus.cmd_len == '0) || (bus.cmd_type == 2'd3)) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (issue) begin
            remaining <= remaining - LEN_BITS'(1);
            if (remaining == LEN_BITS'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave as soon as the last word is leaving this cycle
          if (!inflight && (fifo_count == {1'b0, pop})) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end
        end
        DONE: begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read address pointer: loaded on accept, advances per issued read, wraps
  always_ff @(posedge clk) begin
    if (accept)     ptr <= bus.cmd_base_addr;
    else if (issue) ptr <= ptr + ADDR_BITS'(1);
  end

  // FIFO storage: SRAM data lands the cycle after its read was issued
  always_ff @(posedge clk) begin
    if (inflight) fifo_mem[wr_idx] <= bus.sram_rdata;
  end

`ifdef FEEDER_PERF_CNT_EN
  logic [31:0] stall_cnt;

  // Backpressure counter: selected valid held without ready while streaming
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (accept)
      stall_cnt <= '0;
    else if (((state == STREAM) || (state == DRAIN)) && sel_valid && !sel_ready
             && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign bus.stall_cycles = stall_cnt;
`else
  assign bus.stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_glb_pe_feeder.sv
// Scoreboard bench for glb_pe_feeder: directed commands push expected words
// and read addresses; a negedge monitor pops and compares on every handshake.
module tb_glb_pe_feeder;
  localparam int DW = 16;
  localparam int XW = 4;
  localparam int YW = 4;
  localparam int AW = 16;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  glb_pe_feeder_if #(.DATA_SIZE(DW), .XID_BITS(XW), .YID_BITS(YW),
                     .ADDR_BITS(AW), .LEN_BITS(LW)) bus ();

  glb_pe_feeder #(.DATA_SIZE(DW), .XID_BITS(XW), .YID_BITS(YW),
                  .ADDR_BITS(AW), .LEN_BITS(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]    t;
    logic [DW-1:0] d;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  int vec = 0;
  int miss = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    vec++;
    if (act !== req) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // SRAM model: word at addr is addr+0x100; garbage when not read
  always @(posedge clk)
    bus.sram_rdata <= bus.sram_ren ? DW'(bus.sram_addr + 16'h0100) : 16'hDEAD;

  // Ready driver: all high, or ipsum toggling 1,0,0,1,0,1 with others inverted
  int rmode = 0;
  int pidx = 0;
  logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  always @(posedge clk) begin
    #2;
    if (rmode == 1) begin
      bus.GLB_ipsum_ready  = pat[pidx % 6];
      bus.GLB_ifmap_ready  = !pat[pidx % 6];
      bus.GLB_filter_ready = !pat[pidx % 6];
      pidx++;
    end else begin
      bus.GLB_ipsum_ready  = 1'b1;
      bus.GLB_ifmap_ready  = 1'b1;
      bus.GLB_filter_ready = 1'b1;
    end
  end

  function automatic logic [XW-1:0] tagx(int t);
    case (t)
      0:       return bus.ifmap_tag_X;
      1:       return bus.filter_tag_X;
      default: return bus.ipsum_tag_X;
    endcase
  endfunction

  function automatic logic [YW-1:0] tagy(int t);
    case (t)
      0:       return bus.ifmap_tag_Y;
      1:       return bus.filter_tag_Y;
      default: return bus.ipsum_tag_Y;
    endcase
  endfunction

  // Monitor state
  logic [2:0]    mv, mr;
  logic          prev_hold = 1'b0;
  int            prev_t = 0;
  logic [DW-1:0] prev_d;
  int occ = 0, xnow = 0, xfers = 0, rens = 0, valids_seen = 0, dones = 0, stall_model = 0;
  exp_t          e;

  // Monitor: scoreboard pop on handshake, hold stability, address and credit checks
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
      occ = 0;
    end else begin
      mv = {bus.GLB_ipsum_valid, bus.GLB_filter_valid, bus.GLB_ifmap_valid};
      mr = {bus.GLB_ipsum_ready, bus.GLB_filter_ready, bus.GLB_ifmap_ready};
      if ((mv[0] + mv[1] + mv[2]) > 1) check("one_valid", mv, 0);
      if (prev_hold) begin
        check("hold_valid", mv[prev_t], 1'b1);
        check("hold_data", bus.GLB_data_in, prev_d);
      end
      prev_hold = 1'b0;
      xnow = 0;
      for (int t = 0; t < 3; t++) begin
        if (mv[t]) begin
          valids_seen++;
          if (!mr[t]) begin
            stall_model++;
            prev_hold = 1'b1;
            prev_t = t;
            prev_d = bus.GLB_data_in;
          end else begin
            xnow = 1;
            xfers++;
            if (exp_q.size() == 0) begin
              vec++;
              miss++;
              $display("FAIL sb_extra: got word %0h type %0d, expected none", bus.GLB_data_in, t);
            end else begin
              e = exp_q.pop_front();
              check("sb_type", t, e.t);
              check("sb_data", bus.GLB_data_in, e.d);
              check("sb_tagx", tagx(t), e.x);
              check("sb_tagy", tagy(t), e.y);
            end
          end
        end
      end
      if (bus.sram_ren) begin
        rens++;
        if (addr_q.size() == 0) begin
          vec++;
          miss++;
          $display("FAIL addr_extra: got read at %0h, expected none", bus.sram_addr);
        end else begin
          check("sram_addr", bus.sram_addr, addr_q.pop_front());
        end
        check("credit", (occ + 1 - xnow) <= 2, 1'b1);
      end
      occ = occ + (bus.sram_ren ? 1 : 0) - xnow;
      if (bus.done) dones++;
    end
  end

  task automatic issue(input int t, input logic [AW-1:0] base, input logic [LW-1:0] len,
                       input logic [XW-1:0] x, input logic [YW-1:0] y, output int c0);
    exp_t          ne;
    logic [AW-1:0] a;
    int            n;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) check("cmd_ready_timeout", bus.cmd_ready, 1'b1);
    bus.cmd_type      = 2'(t);
    bus.cmd_base_addr = base;
    bus.cmd_len       = len;
    bus.cmd_tag_X     = x;
    bus.cmd_tag_Y     = y;
    bus.cmd_valid     = 1'b1;
    if (t != 3) begin
      for (int i = 0; i < int'(len); i++) begin
        a = base + AW'(i);
        ne.t = 2'(t);
        ne.d = DW'(a + 16'h0100);
        ne.x = x;
        ne.y = y;
        exp_q.push_back(ne);
        addr_q.push_back(a);
      end
    end
    c0 = cyc;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int rel);
    rel = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.done) begin
        rel = cyc - c0;
        break;
      end
    end
    if (rel < 0) check("done_timeout", 0, 1);
  endtask

  int c0, c1, rel, s0, r0, v0, x0, d0, acc_rel, done_rel, n;

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_type = 2'd0; bus.cmd_base_addr = '0;
    bus.cmd_len = '0; bus.cmd_tag_X = '0; bus.cmd_tag_Y = '0;
    bus.GLB_ifmap_ready = 1'b1; bus.GLB_filter_ready = 1'b1; bus.GLB_ipsum_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valids", {bus.GLB_ifmap_valid, bus.GLB_filter_valid, bus.GLB_ipsum_valid}, 0);
    check("rst_ren", bus.sram_ren, 0);
    check("rst_ready", bus.cmd_ready, 0);
    check("rst_busy_done", {bus.busy, bus.done}, 0);
    check("rst_data", bus.GLB_data_in, 0);
    check("rst_tags", {bus.ifmap_tag_X, bus.filter_tag_X, bus.ipsum_tag_Y}, 0);
    check("rst_stall", bus.stall_cycles, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Filter len 4, ready high: exact cycle timing
    issue(1, 16'h0010, 16'd4, 4'd2, 4'd1, c0);
    for (int r = 1; r <= 8; r++) begin
      @(negedge clk);
      check("t1_filter_valid", bus.GLB_filter_valid, (r >= 3 && r <= 6));
      check("t1_other_valid", {bus.GLB_ifmap_valid, bus.GLB_ipsum_valid}, 0);
      check("t1_done", bus.done, (r == 7));
      if (r == 1) check("t1_first_ren", bus.sram_ren, 1'b1);
      if (r == 3) check("t1_tags", {bus.filter_tag_X, bus.filter_tag_Y}, {4'd2, 4'd1});
      if (r >= 7) check("t1_cmd_ready", bus.cmd_ready, (r == 8));
    end

    // Ipsum len 6 with toggling ready
    rmode = 1;
    s0 = stall_model;
    issue(2, 16'h0040, 16'd6, 4'd5, 4'd3, c0);
    wait_done(c0, rel);
`ifdef FEEDER_PERF_CNT_EN
    check("t2_stall_cycles", bus.stall_cycles, stall_model - s0);
`else
    check("t2_stall_cycles", bus.stall_cycles, 0);
`endif
    rmode = 0;
    check("t2_tags", {bus.ipsum_tag_X, bus.ipsum_tag_Y}, {4'd5, 4'd3});

    // len=0 and reserved type: no traffic, done one cycle after accept
    r0 = rens; v0 = valids_seen;
    issue(0, 16'h0020, 16'd0, 4'd1, 4'd1, c0);
    wait_done(c0, rel);
    check("t3_len0_done_rel", rel, 1);
    issue(3, 16'h0030, 16'd5, 4'd7, 4'd7, c0);
    wait_done(c0, rel);
    check("t3_type3_done_rel", rel, 1);
    repeat (3) @(negedge clk);
    check("t3_no_ren", rens, r0);
    check("t3_no_valid", valids_seen, v0);
    check("t3_tags", {bus.ifmap_tag_X, bus.ifmap_tag_Y, bus.filter_tag_X, bus.ipsum_tag_X},
          {4'd1, 4'd1, 4'd2, 4'd5});

    // Address wrap
    issue(0, 16'hFFFE, 16'd3, 4'd3, 4'd2, c0);
    wait_done(c0, rel);
    check("t4_done_rel", rel, 6);

    // Reset mid-stream after 3 transfers
    x0 = xfers;
    issue(1, 16'h0080, 16'd8, 4'd6, 4'd4, c0);
    n = 0;
    while (xfers < x0 + 3 && n < 50) begin
      @(negedge clk);
      #1 n++;
    end
    check("t5_three_xfers", xfers >= x0 + 3, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    prev_hold = 1'b0;
    occ = 0;
    d0 = dones;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_valids", {bus.GLB_ifmap_valid, bus.GLB_filter_valid, bus.GLB_ipsum_valid}, 0);
    check("t5_ren_data", {bus.sram_ren, bus.GLB_data_in}, 0);
    check("t5_status", {bus.busy, bus.done, bus.cmd_ready}, 0);
    check("t5_filter_tags", {bus.filter_tag_X, bus.filter_tag_Y}, 0);
    repeat (4) @(negedge clk);
    check("t5_no_done", dones, d0);
    issue(0, 16'h0200, 16'd2, 4'd9, 4'd8, c0);
    wait_done(c0, rel);
    check("t5_done_rel", rel, 5);
    check("t5_tags_after", {bus.ifmap_tag_X, bus.ifmap_tag_Y, bus.filter_tag_X, bus.filter_tag_Y},
          {4'd9, 4'd8, 4'd0, 4'd0});

    // Back-to-back with cmd_valid held high
    issue(0, 16'h0300, 16'd2, 4'd1, 4'd2, c0);
    bus.cmd_valid = 1'b1;
    bus.cmd_type = 2'd1; bus.cmd_base_addr = 16'h0310; bus.cmd_len = 16'd2;
    bus.cmd_tag_X = 4'd3; bus.cmd_tag_Y = 4'd4;
    for (int i = 0; i < 2; i++) begin
      e.t = 2'd1; e.d = DW'(16'h0410 + i); e.x = 4'd3; e.y = 4'd4;
      exp_q.push_back(e);
      addr_q.push_back(AW'(16'h0310 + i));
    end
    acc_rel = -1; done_rel = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) done_rel = cyc - c0;
      if (bus.cmd_ready) begin
        acc_rel = cyc - c0;
        break;
      end
    end
    check("t6_first_done_rel", done_rel, 5);
    check("t6_accept_rel", acc_rel, 6);
    c1 = cyc;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    wait_done(c1, rel);
    check("t6_second_done_rel", rel, 5);
    check("t6_tags", {bus.ifmap_tag_X, bus.ifmap_tag_Y, bus.filter_tag_X, bus.filter_tag_Y},
          {4'd1, 4'd2, 4'd3, 4'd4});

    repeat (5) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    check("addr_q_empty", addr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
